// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes, memory-wait freeze
// with timeout abort, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 16,
  parameter int REG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             mem_branch_taken_i,
  input  logic             mem_op_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             pc_sel_branch_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_write_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic             mem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze, lu_match, lu_bubble, stall_inc;

  // wait_cnt holds the number of freeze cycles already spent on this access;
  // the RUN cycle that issued the request is cycle 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == ABORT) mem_err_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_op_i && !mem_ack_i) begin
          state_nxt = WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ack_i || !mem_op_i) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = ABORT;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ABORT: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  assign freeze   = (state != ABORT) && mem_op_i && !mem_ack_i;
  assign lu_match = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // Priority: reset > freeze > branch > load-use > normal advance.
  always_comb begin
    pc_write_o      = 1'b1;
    pc_sel_branch_o = 1'b0;
    ifid_write_o    = 1'b1;
    ifid_flush_o    = 1'b0;
    idex_write_o    = 1'b1;
    idex_flush_o    = 1'b0;
    exmem_write_o   = 1'b1;
    exmem_flush_o   = 1'b0;
    memwb_flush_o   = 1'b0;
    mem_req_o       = mem_op_i && (state != ABORT);
    lu_bubble       = 1'b0;
    if (rst_i) begin
      mem_req_o = 1'b0;
    end else if (freeze) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      memwb_flush_o = 1'b1;
    end else begin
      if (mem_branch_taken_i) begin
        pc_sel_branch_o = 1'b1;
        ifid_flush_o    = 1'b1;
        idex_flush_o    = 1'b1;
        exmem_flush_o   = 1'b1;
      end else if (lu_match) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
        lu_bubble    = 1'b1;
      end
      // The aborted access must not reach write-back.
      if (state == ABORT) memwb_flush_o = 1'b1;
    end
  end

  assign stall_inc = !rst_i && (freeze || lu_bubble);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .clr (rst_i),
    .inc (stall_inc),
    .q   (stall_cnt_o)
  );

endmodule
